// File: rtl/pc.sv
// Program counter for the single-cycle RV32I core.
// Holds the current fetch address and selects the next one from the decoded
// control-unit operation: sequential (+4), PC-relative jump/branch, or the
// register-indirect JALR target. The register only advances when the fetched
// instruction is ready, and a synchronous active-high reset returns it to 0.
module pc (
    input  logic        clk,
    input  logic        nRST,
    input  logic [5:0]  cuOP,
    input  logic [31:0] rs1Read,
    input  logic [31:0] signExtend,
    input  logic        ALUneg,
    input  logic        Zero,
    input  logic        iready,
    output logic [31:0] PCaddr
);

    // Control-flow members of the control-unit operation encoding; every other
    // value (LUI, AUIPC, ALU ops, ERROR and unused codes) falls through to +4.
    localparam logic [5:0] OP_JAL  = 6'd2;
    localparam logic [5:0] OP_JALR = 6'd3;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_BNE  = 6'd5;
    localparam logic [5:0] OP_BLT  = 6'd6;
    localparam logic [5:0] OP_BGE  = 6'd7;
    localparam logic [5:0] OP_BLTU = 6'd8;
    localparam logic [5:0] OP_BGEU = 6'd9;

    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] seq_pc;
    logic [31:0] rel_pc;
    logic [31:0] jalr_sum;
    logic        taken;

    // Candidate targets; all adds wrap modulo 2^32 with no alignment check.
    assign seq_pc   = pc_q + 32'd4;
    assign rel_pc   = pc_q + signExtend;
    assign jalr_sum = rs1Read + signExtend;

    // Branch condition from the ALU flags. BGE/BGEU also accept Zero so that
    // equality counts as taken even if the less-than flag is set alongside it.
    always_comb begin
        taken = 1'b0;
        unique case (cuOP)
            OP_BEQ:          taken = Zero;
            OP_BNE:          taken = ~Zero;
            OP_BLT, OP_BLTU: taken = ALUneg;
            OP_BGE, OP_BGEU: taken = ~ALUneg | Zero;
            default:         taken = 1'b0;
        endcase
    end

    // Next-PC selection; only JALR clears bit 0 of its target.
    always_comb begin
        pc_d = seq_pc;
        unique case (cuOP)
            OP_JAL:  pc_d = rel_pc;
            OP_JALR: pc_d = {jalr_sum[31:1], 1'b0};
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU:
                     pc_d = taken ? rel_pc : seq_pc;
            default: pc_d = seq_pc;
        endcase
    end

    // PC register: reset wins over iready; otherwise advance only when ready.
    always_ff @(posedge clk) begin
        if (nRST) begin
            pc_q <= RESET_ADDR;
        end else if (iready) begin
            pc_q <= pc_d;
        end
    end

    assign PCaddr = pc_q;

endmodule

// File: tb/tb_pc.sv
// Self-checking bench for pc: directed cases with literal expectations plus a
// randomized run, all compared every cycle against a behavioural PC model.
module tb_pc;

    logic        clk;
    logic        nRST;
    logic [5:0]  cuOP;
    logic [31:0] rs1Read;
    logic [31:0] signExtend;
    logic        ALUneg;
    logic        Zero;
    logic        iready;
    logic [31:0] PCaddr;

    int n_total = 0;
    int n_pass  = 0;

    logic [31:0] exp_pc;
    logic        exp_valid = 1'b0;

    pc dut (
        .clk        (clk),
        .nRST       (nRST),
        .cuOP       (cuOP),
        .rs1Read    (rs1Read),
        .signExtend (signExtend),
        .ALUneg     (ALUneg),
        .Zero       (Zero),
        .iready     (iready),
        .PCaddr     (PCaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: what the next instruction address must be, straight from the rules.
    function automatic logic [31:0] model_next(input int op, input logic [31:0] cur,
                                               input logic [31:0] rs1, input logic [31:0] imm,
                                               input bit neg, input bit z);
        bit br;
        logic [31:0] t;
        br = 0;
        if (op == 2) return cur + imm;
        if (op == 3) begin
            t = rs1 + imm;
            t[0] = 1'b0;
            return t;
        end
        if (op >= 4 && op <= 9) begin
            case (op)
                4: br = z;
                5: br = !z;
                6, 8: br = neg;
                default: br = !neg || z;
            endcase
            return br ? cur + imm : cur + 32'd4;
        end
        return cur + 32'd4;
    endfunction

    // Model state update on the same edge as the DUT.
    always @(posedge clk) begin
        if (nRST === 1'b1) begin
            exp_pc    = 32'h0;
            exp_valid = 1'b1;
        end else if (exp_valid && iready === 1'b1) begin
            exp_pc = model_next(int'(cuOP), exp_pc, rs1Read, signExtend, ALUneg, Zero);
        end
    end

    // Continuous compare against the model once it has seen a reset.
    always @(negedge clk) begin
        if (exp_valid) begin
            n_total++;
            if (PCaddr === exp_pc) n_pass++;
            else $display("FAIL model_cmp t=%0t PCaddr=%h expected=%h", $time, PCaddr, exp_pc);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s PCaddr=%h expected=%h", nm, act, req);
    endtask

    // Drive one cycle of inputs just after a falling edge, then wait to the next falling edge.
    task automatic step(input logic rst, input logic [5:0] op, input logic [31:0] rs1,
                        input logic [31:0] imm, input logic neg, input logic z, input logic rdy);
        nRST = rst; cuOP = op; rs1Read = rs1; signExtend = imm;
        ALUneg = neg; Zero = z; iready = rdy;
        @(negedge clk);
    endtask

    task automatic rst1();
        step(1'b1, 6'd2, 32'h0, 32'h40, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        nRST = 1'b1; cuOP = 6'd2; rs1Read = 32'h0; signExtend = 32'h44;
        ALUneg = 1'b0; Zero = 1'b0; iready = 1'b1;
        @(negedge clk);

        // Reset for two edges with a jump pending and iready high.
        step(1'b1, 6'd2, 32'h0, 32'h44, 1'b0, 1'b0, 1'b1);
        chk("reset", PCaddr, 32'h0);
        step(1'b1, 6'd3, 32'h123, 32'h10, 1'b1, 1'b1, 1'b1);
        chk("reset_hold", PCaddr, 32'h0);

        // JAL stepping and wrap.
        step(1'b0, 6'd2, 32'h0, 32'd8, 1'b0, 1'b0, 1'b1);
        chk("jal_8", PCaddr, 32'd8);
        step(1'b0, 6'd2, 32'h0, 32'd8, 1'b0, 1'b0, 1'b1);
        chk("jal_16", PCaddr, 32'd16);
        step(1'b0, 6'd2, 32'h0, 32'd8, 1'b0, 1'b0, 1'b1);
        chk("jal_24", PCaddr, 32'd24);
        rst1();
        step(1'b0, 6'd2, 32'h0, 32'd8, 1'b0, 1'b0, 1'b1);
        step(1'b0, 6'd2, 32'h0, 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b1);
        chk("jal_wrap", PCaddr, 32'h0);

        // JALR with bit 0 cleared.
        step(1'b0, 6'd3, 32'd5, 32'd2, 1'b0, 1'b0, 1'b1);
        chk("jalr_6", PCaddr, 32'd6);
        step(1'b0, 6'd3, 32'h100, 32'd1, 1'b0, 1'b0, 1'b1);
        chk("jalr_100", PCaddr, 32'h100);

        // Branches from 0 with offset 16.
        rst1(); step(1'b0, 6'd4, 32'h0, 32'd16, 1'b0, 1'b0, 1'b1); chk("beq_nt", PCaddr, 32'd4);
        rst1(); step(1'b0, 6'd4, 32'h0, 32'd16, 1'b0, 1'b1, 1'b1); chk("beq_t", PCaddr, 32'd16);
        rst1(); step(1'b0, 6'd5, 32'h0, 32'd16, 1'b0, 1'b1, 1'b1); chk("bne_nt", PCaddr, 32'd4);
        rst1(); step(1'b0, 6'd5, 32'h0, 32'd16, 1'b0, 1'b0, 1'b1); chk("bne_t", PCaddr, 32'd16);
        rst1(); step(1'b0, 6'd6, 32'h0, 32'd16, 1'b1, 1'b0, 1'b1); chk("blt_t", PCaddr, 32'd16);
        rst1(); step(1'b0, 6'd6, 32'h0, 32'd16, 1'b0, 1'b0, 1'b1); chk("blt_nt", PCaddr, 32'd4);
        rst1(); step(1'b0, 6'd8, 32'h0, 32'd16, 1'b1, 1'b0, 1'b1); chk("bltu_t", PCaddr, 32'd16);
        rst1(); step(1'b0, 6'd8, 32'h0, 32'd16, 1'b0, 1'b0, 1'b1); chk("bltu_nt", PCaddr, 32'd4);
        rst1(); step(1'b0, 6'd7, 32'h0, 32'd16, 1'b1, 1'b1, 1'b1); chk("bge_eq", PCaddr, 32'd16);
        rst1(); step(1'b0, 6'd7, 32'h0, 32'd16, 1'b0, 1'b0, 1'b1); chk("bge_gt", PCaddr, 32'd16);
        rst1(); step(1'b0, 6'd7, 32'h0, 32'd16, 1'b1, 1'b0, 1'b1); chk("bge_nt", PCaddr, 32'd4);
        rst1(); step(1'b0, 6'd9, 32'h0, 32'd16, 1'b1, 1'b1, 1'b1); chk("bgeu_eq", PCaddr, 32'd16);
        rst1(); step(1'b0, 6'd9, 32'h0, 32'd16, 1'b0, 1'b0, 1'b1); chk("bgeu_gt", PCaddr, 32'd16);
        rst1(); step(1'b0, 6'd9, 32'h0, 32'd16, 1'b1, 1'b0, 1'b1); chk("bgeu_nt", PCaddr, 32'd4);

        // Stall holds, then ADD / LUI / ERROR / undefined codes step by 4.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 6'd2, 32'h0, 32'd64, 1'b0, 1'b0, 1'b0);
            chk("stall", PCaddr, 32'd4);
        end
        step(1'b0, 6'd28, 32'h0, 32'd64, 1'b1, 1'b1, 1'b1); chk("add_1", PCaddr, 32'd8);
        step(1'b0, 6'd28, 32'h0, 32'd64, 1'b0, 1'b1, 1'b1); chk("add_2", PCaddr, 32'd12);
        step(1'b0, 6'd0,  32'h0, 32'd64, 1'b0, 1'b1, 1'b1); chk("lui", PCaddr, 32'd16);
        step(1'b0, 6'd38, 32'h0, 32'd64, 1'b0, 1'b1, 1'b1); chk("error", PCaddr, 32'd20);
        step(1'b0, 6'd50, 32'h0, 32'd64, 1'b0, 1'b1, 1'b1); chk("undef", PCaddr, 32'd24);

        // Reset overrides a ready jump mid-stream.
        step(1'b1, 6'd2, 32'h0, 32'd64, 1'b0, 1'b0, 1'b1); chk("reset_mid", PCaddr, 32'h0);

        // Randomized run; the compare process checks every cycle.
        for (int i = 0; i < 600; i++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 9)) : 6'($urandom_range(0, 63));
            step(($urandom_range(0, 49) == 0), op, $urandom, $urandom,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 4) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
